// File: rtl/stride_prefetch_sequencer.sv
// Turns stride-detector findings into bursts of predicted prefetch addresses
// on a valid/ready port, with a one-entry pending slot for triggers mid-burst.
module stride_prefetch_sequencer #(
    parameter int unsigned MAX_STRIDE_WIDTH = 5,
    parameter int unsigned PREFETCH_DEPTH   = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        enable_i,
    input  logic [31:0]                 value_i,
    input  logic                        valid_i,
    input  logic [MAX_STRIDE_WIDTH-1:0] stride_1_i,
    input  logic                        stride_1_valid_i,
    input  logic [MAX_STRIDE_WIDTH-1:0] stride_2_i,
    input  logic                        stride_2_valid_i,
    output logic [31:0]                 prefetch_addr_o,
    output logic                        prefetch_valid_o,
    input  logic                        prefetch_ready_i,
    output logic                        busy_o,
    output logic                        dropped_o
);

    localparam int unsigned CntW = $clog2(PREFETCH_DEPTH + 1);
    localparam int unsigned ExtW = 32 - MAX_STRIDE_WIDTH;

    typedef enum logic [0:0] {StIdle, StIssue} state_e;

    state_e state_q, state_d;

    logic                        phase_q, phase_d;
    logic [CntW-1:0]             count_q, count_d;
    logic [31:0]                 addr_q, addr_d;
    logic [31:0]                 slot0_q, slot0_d;
    logic [31:0]                 slot1_q, slot1_d;
    logic                        sel_q, sel_d;
    logic                        pend_valid_q, pend_valid_d;
    logic [31:0]                 pend_value_q, pend_value_d;
    logic [MAX_STRIDE_WIDTH-1:0] pend_s1_q, pend_s1_d;
    logic [MAX_STRIDE_WIDTH-1:0] pend_s2_q, pend_s2_d;
    logic                        pend_s1v_q, pend_s1v_d;
    logic                        pend_s2v_q, pend_s2v_d;
    logic                        pend_phase_q, pend_phase_d;
    logic                        dropped_q, dropped_d;

    function automatic logic [31:0] sext(input logic [MAX_STRIDE_WIDTH-1:0] s);
        return {{ExtW{s[MAX_STRIDE_WIDTH-1]}}, s};
    endfunction

    logic                        trig, handshake, pend_live, restart, last, load;
    logic [CntW-1:0]             count_inc;
    logic [31:0]                 src_value;
    logic [MAX_STRIDE_WIDTH-1:0] src_s1, src_s2;
    logic                        src_s1v, src_s2v, src_phase;
    logic                        src_two, src_null, first_slot;
    logic [31:0]                 src_slot0, src_slot1, src_first_addr;

    assign trig      = valid_i && enable_i;
    assign handshake = (state_q == StIssue) && prefetch_ready_i;
    assign pend_live = pend_valid_q && enable_i;
    assign restart   = trig || pend_live;
    assign count_inc = count_q + CntW'(1);
    assign last      = (count_inc == CntW'(PREFETCH_DEPTH));

    // A live trigger is always the newest, so it wins over the pending entry.
    always_comb begin
        if (trig) begin
            src_value = value_i;
            src_s1    = stride_1_i;
            src_s1v   = stride_1_valid_i;
            src_s2    = stride_2_i;
            src_s2v   = stride_2_valid_i;
            src_phase = phase_q;
        end else begin
            src_value = pend_value_q;
            src_s1    = pend_s1_q;
            src_s1v   = pend_s1v_q;
            src_s2    = pend_s2_q;
            src_s2v   = pend_s2v_q;
            src_phase = pend_phase_q;
        end
        src_two        = src_s2v;
        src_null       = !src_two && !(src_s1v && (src_s1 != '0));
        first_slot     = src_two ? !src_phase : 1'b0;
        src_slot0      = sext(src_s1);
        src_slot1      = src_two ? sext(src_s2) : sext(src_s1);
        src_first_addr = src_value + (first_slot ? src_slot1 : src_slot0);
    end

    assign load = !src_null && (((state_q == StIdle) && trig) || (handshake && restart));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (trig && !src_null) state_d = StIssue;
            end
            StIssue: begin
                if (handshake) begin
                    if (restart) begin
                        state_d = src_null ? StIdle : StIssue;
                    end else if (last || !enable_i) begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        prefetch_valid_o = (state_q == StIssue);
        busy_o           = (state_q == StIssue);
        prefetch_addr_o  = addr_q;
        dropped_o        = dropped_q;
    end

    // Single mode stores the same stride in both slots so the selector can toggle freely.
    always_comb begin
        addr_d  = addr_q;
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        sel_d   = sel_q;
        count_d = count_q;
        phase_d = phase_q ^ valid_i;
        if (load) begin
            addr_d  = src_first_addr;
            slot0_d = src_slot0;
            slot1_d = src_slot1;
            sel_d   = !first_slot;
            count_d = '0;
        end else if (handshake) begin
            addr_d  = addr_q + (sel_q ? slot1_q : slot0_q);
            sel_d   = !sel_q;
            count_d = count_inc;
        end
    end

    always_comb begin
        pend_valid_d = pend_valid_q;
        pend_value_d = pend_value_q;
        pend_s1_d    = pend_s1_q;
        pend_s1v_d   = pend_s1v_q;
        pend_s2_d    = pend_s2_q;
        pend_s2v_d   = pend_s2v_q;
        pend_phase_d = pend_phase_q;
        dropped_d    = 1'b0;
        if (!enable_i) begin
            pend_valid_d = 1'b0;
        end else if (state_q == StIssue) begin
            if (handshake) begin
                pend_valid_d = 1'b0;
                dropped_d    = trig && pend_valid_q;
            end else if (trig) begin
                pend_valid_d = 1'b1;
                pend_value_d = value_i;
                pend_s1_d    = stride_1_i;
                pend_s1v_d   = stride_1_valid_i;
                pend_s2_d    = stride_2_i;
                pend_s2v_d   = stride_2_valid_i;
                pend_phase_d = phase_q;
                dropped_d    = pend_valid_q;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            phase_q      <= 1'b0;
            count_q      <= '0;
            addr_q       <= '0;
            slot0_q      <= '0;
            slot1_q      <= '0;
            sel_q        <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_value_q <= '0;
            pend_s1_q    <= '0;
            pend_s1v_q   <= 1'b0;
            pend_s2_q    <= '0;
            pend_s2v_q   <= 1'b0;
            pend_phase_q <= 1'b0;
            dropped_q    <= 1'b0;
        end else begin
            phase_q      <= phase_d;
            count_q      <= count_d;
            addr_q       <= addr_d;
            slot0_q      <= slot0_d;
            slot1_q      <= slot1_d;
            sel_q        <= sel_d;
            pend_valid_q <= pend_valid_d;
            pend_value_q <= pend_value_d;
            pend_s1_q    <= pend_s1_d;
            pend_s1v_q   <= pend_s1v_d;
            pend_s2_q    <= pend_s2_d;
            pend_s2v_q   <= pend_s2v_d;
            pend_phase_q <= pend_phase_d;
            dropped_q    <= dropped_d;
        end
    end

endmodule

// File: tb/tb_stride_prefetch_sequencer.sv
// Bench for stride_prefetch_sequencer: constant vector table, directed corner
// sequences and random traffic against a queue-based burst model.
module tb_stride_prefetch_sequencer;

    localparam int W = 5;
    localparam int D = 4;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          enable_i = 1'b0;
    logic [31:0]   value_i = '0;
    logic          valid_i = 1'b0;
    logic [W-1:0]  stride_1_i = '0;
    logic          stride_1_valid_i = 1'b0;
    logic [W-1:0]  stride_2_i = '0;
    logic          stride_2_valid_i = 1'b0;
    logic          prefetch_ready_i = 1'b0;
    logic [31:0]   prefetch_addr_o;
    logic          prefetch_valid_o;
    logic          busy_o;
    logic          dropped_o;

    stride_prefetch_sequencer #(
        .MAX_STRIDE_WIDTH(W),
        .PREFETCH_DEPTH  (D)
    ) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .enable_i        (enable_i),
        .value_i         (value_i),
        .valid_i         (valid_i),
        .stride_1_i      (stride_1_i),
        .stride_1_valid_i(stride_1_valid_i),
        .stride_2_i      (stride_2_i),
        .stride_2_valid_i(stride_2_valid_i),
        .prefetch_addr_o (prefetch_addr_o),
        .prefetch_valid_o(prefetch_valid_o),
        .prefetch_ready_i(prefetch_ready_i),
        .busy_o          (busy_o),
        .dropped_o       (dropped_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int failures = 0;
    int drop_seen = 0;

    typedef struct packed {
        logic [31:0]  value;
        logic [W-1:0] s1;
        logic         s1v;
        logic [W-1:0] s2;
        logic         s2v;
        logic         phase;
    } trig_t;

    // Model: the remaining addresses of the current burst, plus one pending trigger.
    logic [31:0] m_q[$];
    trig_t       m_pend;
    logic        m_pend_v = 1'b0;
    logic        m_phase = 1'b0;
    logic        m_drop = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic void gen_burst(input trig_t t);
        int          sa, sb;
        int unsigned slot;
        logic [31:0] a;
        m_q.delete();
        if (!t.s2v && !(t.s1v && t.s1 != '0)) return;
        sa = int'($signed(t.s1));
        if (t.s2v) sb = int'($signed(t.s2));
        else sb = sa;
        slot = t.s2v ? 32'(!t.phase) : 0;
        a = t.value;
        for (int i = 0; i < D; i++) begin
            a = a + ((slot == 0) ? 32'(sa) : 32'(sb));
            m_q.push_back(a);
            if (t.s2v) slot = slot ^ 1;
        end
    endfunction

    function automatic trig_t live_trig();
        trig_t t;
        t.value = value_i;
        t.s1    = stride_1_i;
        t.s1v   = stride_1_valid_i;
        t.s2    = stride_2_i;
        t.s2v   = stride_2_valid_i;
        t.phase = m_phase;
        return t;
    endfunction

    function automatic void model_reset();
        m_q.delete();
        m_pend_v = 1'b0;
        m_phase  = 1'b0;
        m_drop   = 1'b0;
    endfunction

    function automatic void model_update();
        trig_t lt;
        logic  trig, hs, drop;
        lt   = live_trig();
        trig = valid_i && enable_i;
        hs   = (m_q.size() > 0) && prefetch_ready_i;
        drop = 1'b0;
        if (m_q.size() == 0) begin
            if (trig) gen_burst(lt);
        end else if (hs) begin
            void'(m_q.pop_front());
            if (trig) begin
                drop = m_pend_v;
                gen_burst(lt);
                m_pend_v = 1'b0;
            end else if (m_pend_v && enable_i) begin
                gen_burst(m_pend);
                m_pend_v = 1'b0;
            end else if (!enable_i) begin
                m_q.delete();
                m_pend_v = 1'b0;
            end
        end else begin
            if (!enable_i) begin
                m_pend_v = 1'b0;
            end else if (trig) begin
                drop     = m_pend_v;
                m_pend   = lt;
                m_pend_v = 1'b1;
            end
        end
        m_drop = drop;
        if (valid_i) m_phase = ~m_phase;
    endfunction

    task automatic check_outputs();
        logic exp_valid;
        exp_valid = (m_q.size() > 0);
        chk("valid", 32'(prefetch_valid_o), 32'(exp_valid));
        chk("busy", 32'(busy_o), 32'(exp_valid));
        chk("dropped", 32'(dropped_o), 32'(m_drop));
        if (exp_valid) chk("addr", prefetch_addr_o, m_q[0]);
    endtask

    task automatic tick();
        @(posedge clk_i);
        if (rst_ni) model_update();
        else model_reset();
        #1;
        if (dropped_o === 1'b1) drop_seen++;
        check_outputs();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, ".valid"}, 32'(prefetch_valid_o), 32'd0);
        chk({tag, ".busy"}, 32'(busy_o), 32'd0);
        chk({tag, ".dropped"}, 32'(dropped_o), 32'd0);
        chk({tag, ".addr"}, prefetch_addr_o, 32'd0);
    endtask

    task automatic do_reset();
        #3;
        rst_ni = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        model_reset();
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    task automatic drive(input logic v, input logic [31:0] val, input logic [W-1:0] s1,
                         input logic s1v, input logic [W-1:0] s2, input logic s2v);
        valid_i          = v;
        value_i          = val;
        stride_1_i       = s1;
        stride_1_valid_i = s1v;
        stride_2_i       = s2;
        stride_2_valid_i = s2v;
    endtask

    typedef struct packed {
        logic [31:0]  value;
        logic [W-1:0] s1;
        logic         s1v;
        logic [W-1:0] s2;
        logic         s2v;
        logic         phase;
        logic [127:0] exp;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{32'h0000_1000, 5'b00100, 1'b1, 5'b00000, 1'b0, 1'b0,
                    {32'h0000_1010, 32'h0000_100C, 32'h0000_1008, 32'h0000_1004}};
        vecs[1] = '{32'h0000_0200, 5'b00010, 1'b1, 5'b11101, 1'b1, 1'b1,
                    {32'h0000_01FE, 32'h0000_0201, 32'h0000_01FF, 32'h0000_0202}};
        vecs[2] = '{32'h0000_0200, 5'b00010, 1'b1, 5'b11101, 1'b1, 1'b0,
                    {32'h0000_01FE, 32'h0000_01FC, 32'h0000_01FF, 32'h0000_01FD}};
        vecs[3] = '{32'hFFFF_FFFE, 5'b00100, 1'b1, 5'b00000, 1'b0, 1'b1,
                    {32'h0000_000E, 32'h0000_000A, 32'h0000_0006, 32'h0000_0002}};
        vecs[4] = '{32'h0000_0010, 5'b11111, 1'b1, 5'b10000, 1'b1, 1'b0,
                    {32'hFFFF_FFEE, 32'hFFFF_FFEF, 32'hFFFF_FFFF, 32'h0000_0000}};
        vecs[5] = '{32'h7FFF_FFF8, 5'b01111, 1'b1, 5'b10101, 1'b0, 1'b0,
                    {32'h8000_0034, 32'h8000_0025, 32'h8000_0016, 32'h8000_0007}};

        #12;
        check_reset_outputs("reset");
        model_reset();
        @(negedge clk_i);
        rst_ni = 1'b1;
        enable_i = 1'b1;
        prefetch_ready_i = 1'b1;
        tick();

        for (int v = 0; v < 6; v++) begin
            if (m_phase != vecs[v].phase) begin
                enable_i = 1'b0;
                drive(1'b1, 32'h0, '0, 1'b0, '0, 1'b0);
                tick();
                enable_i = 1'b1;
            end
            prefetch_ready_i = 1'b1;
            drive(1'b1, vecs[v].value, vecs[v].s1, vecs[v].s1v, vecs[v].s2, vecs[v].s2v);
            tick();
            valid_i = 1'b0;
            for (int i = 0; i < D; i++) begin
                chk($sformatf("vec%0d.addr%0d", v, i), prefetch_addr_o, vecs[v].exp[i*32 +: 32]);
                chk($sformatf("vec%0d.valid%0d", v, i), 32'(prefetch_valid_o), 32'd1);
                tick();
            end
            chk($sformatf("vec%0d.end_busy", v), 32'(busy_o), 32'd0);
        end

        // Backpressure with two triggers queued behind the first address.
        prefetch_ready_i = 1'b0;
        drive(1'b1, 32'h2000, 5'b00001, 1'b1, '0, 1'b0);
        tick();
        drive(1'b1, 32'h3000, 5'b00001, 1'b1, '0, 1'b0);
        tick();
        drop_seen = 0;
        drive(1'b1, 32'h4000, 5'b00001, 1'b1, '0, 1'b0);
        tick();
        valid_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp.hold_addr", prefetch_addr_o, 32'h2001);
        end
        prefetch_ready_i = 1'b1;
        tick();
        chk("bp.restart0", prefetch_addr_o, 32'h4001);
        tick();
        chk("bp.restart1", prefetch_addr_o, 32'h4002);
        chk("bp.drop_count", 32'(drop_seen), 32'd1);
        repeat (3) tick();
        chk("bp.end_busy", 32'(busy_o), 32'd0);

        // Null and zero-stride triggers, then a null trigger pending mid-burst.
        drive(1'b1, 32'h5000, 5'b00011, 1'b0, 5'b00011, 1'b0);
        tick();
        chk("null.valid", 32'(prefetch_valid_o), 32'd0);
        drive(1'b1, 32'h5000, 5'b00000, 1'b1, 5'b00000, 1'b0);
        tick();
        chk("zero.busy", 32'(busy_o), 32'd0);
        prefetch_ready_i = 1'b0;
        drive(1'b1, 32'h0100, 5'b00001, 1'b1, '0, 1'b0);
        tick();
        drive(1'b1, 32'h0900, 5'b00001, 1'b0, '0, 1'b0);
        tick();
        valid_i = 1'b0;
        prefetch_ready_i = 1'b1;
        tick();
        chk("null_pend.busy", 32'(busy_o), 32'd0);

        // enable_i dropped while the request is stalled.
        prefetch_ready_i = 1'b0;
        drive(1'b1, 32'h0500, 5'b00010, 1'b1, '0, 1'b0);
        tick();
        valid_i = 1'b0;
        enable_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("en.hold_addr", prefetch_addr_o, 32'h0502);
        end
        prefetch_ready_i = 1'b1;
        tick();
        chk("en.idle", 32'(prefetch_valid_o), 32'd0);
        enable_i = 1'b1;

        // Reset in the middle of a stalled burst, then phase must restart at 0.
        prefetch_ready_i = 1'b0;
        drive(1'b1, 32'h0600, 5'b00001, 1'b1, '0, 1'b0);
        tick();
        valid_i = 1'b0;
        do_reset();
        drive(1'b1, 32'h0200, 5'b00010, 1'b1, 5'b11101, 1'b1);
        tick();
        chk("post_reset.phase0_addr", prefetch_addr_o, 32'h01FD);
        valid_i = 1'b0;
        prefetch_ready_i = 1'b1;
        repeat (4) tick();

        for (int c = 0; c < 800; c++) begin
            enable_i         = ($urandom_range(99) < 90);
            prefetch_ready_i = ($urandom_range(99) < 55);
            drive($urandom_range(99) < 35,
                  ($urandom_range(9) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom,
                  W'($urandom), $urandom_range(99) < 70,
                  W'($urandom), $urandom_range(99) < 35);
            if ($urandom_range(199) == 0) do_reset();
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
